assoc_cache: RTL

- Parametrised 2-way set-associative, write-back, write-allocate data cache.
- Sits between the CPU load/store port (8-bit bytes, READ/WRITE/BUSYWAIT) and the block-wide data memory (MEM_* handshake).
- Generalises the current direct-mapped cache in set count, block size and address width.
- Adds true-LRU replacement per set and saturating hit/miss performance counters.

---
 rtl/assoc_cache.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/assoc_cache.sv
// 2-way set-associative, write-back, write-allocate data cache.
// True-LRU replacement per set, saturating hit/miss performance counters.
module assoc_cache #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SETS        = 4,
    parameter int unsigned BLOCK_BYTES = 4,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned OFF        = $clog2(BLOCK_BYTES),
    localparam int unsigned IDX        = $clog2(SETS),
    localparam int unsigned TAG        = ADDR_W - IDX - OFF,
    localparam int unsigned MA_W       = ADDR_W - OFF,
    localparam int unsigned BLK_W      = 8 * BLOCK_BYTES
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [7:0]        WRITEDATA,
    output logic [7:0]        READDATA,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [MA_W-1:0]   MEM_ADDRESS,
    output logic [BLK_W-1:0]  MEM_WRITEDATA,
    input  logic [BLK_W-1:0]  MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic [CNT_W-1:0]  HIT_COUNT,
    output logic [CNT_W-1:0]  MISS_COUNT
);

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch, StUpdate} state_e;

    state_e           state_q, state_d;
    logic [1:0]       valid_q [SETS];
    logic [1:0]       dirty_q [SETS];
    logic [SETS-1:0]  lru_q;
    logic [TAG-1:0]   tag_q   [SETS][2];
    logic [BLK_W-1:0] data_q  [SETS][2];

    logic             victim_q, victim_d;
    logic             refill_q, refill_d;
    logic [BLK_W-1:0] block_q, block_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [MA_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [TAG-1:0]   req_tag;
    logic [IDX-1:0]   req_idx;
    logic [OFF-1:0]   req_off;
    logic             req;
    logic [1:0]       way_hit;
    logic             hit, hit_way, victim_way, victim_dirty;
    logic             hit_acc, fill;

    assign req_tag = ADDRESS[ADDR_W-1 -: TAG];
    assign req_idx = ADDRESS[OFF +: IDX];
    assign req_off = ADDRESS[OFF-1:0];
    assign req     = READ | WRITE;

    // Combinational lookup and victim choice for the addressed set
    always_comb begin
        way_hit[0]   = valid_q[req_idx][0] && (tag_q[req_idx][0] == req_tag);
        way_hit[1]   = valid_q[req_idx][1] && (tag_q[req_idx][1] == req_tag);
        hit          = |way_hit;
        hit_way      = way_hit[1];
        READDATA     = hit ? 8'(data_q[req_idx][hit_way] >> {req_off, 3'b000}) : 8'h00;
        if (!valid_q[req_idx][0]) begin
            victim_way = 1'b0;
        end else if (!valid_q[req_idx][1]) begin
            victim_way = 1'b1;
        end else begin
            victim_way = lru_q[req_idx];
        end
        victim_dirty = valid_q[req_idx][victim_way] && dirty_q[req_idx][victim_way];
    end

    // Next-state, registered memory-port outputs and counters
    always_comb begin
        state_d     = state_q;
        victim_d    = victim_q;
        refill_d    = refill_q;
        block_d     = block_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        hit_acc     = 1'b0;
        fill        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req && hit) begin
                    hit_acc  = 1'b1;
                    refill_d = 1'b0;
                    // The retry after a refill was already counted as a miss
                    if (!refill_q && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                end else if (req) begin
                    refill_d = 1'b1;
                    victim_d = victim_way;
                    if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    if (victim_dirty) begin
                        state_d     = StWriteback;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[req_idx][victim_way], req_idx};
                        mem_wdata_d = data_q[req_idx][victim_way];
                    end else begin
                        state_d    = StFetch;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
            end
            StWriteback: begin
                if (!MEM_BUSYWAIT) begin
                    state_d     = StFetch;
                    mem_write_d = 1'b0;
                    mem_wdata_d = '0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {req_tag, req_idx};
                end
            end
            StFetch: begin
                if (!MEM_BUSYWAIT) begin
                    state_d    = StUpdate;
                    block_d    = MEM_READDATA;
                    mem_read_d = 1'b0;
                    mem_addr_d = '0;
                end
            end
            StUpdate: begin
                fill    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= StIdle;
            victim_q    <= 1'b0;
            refill_q    <= 1'b0;
            block_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            refill_q    <= refill_d;
            block_q     <= block_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Line status bits: cleared by reset, set by refill and store hits
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            lru_q   <= '0;
        end else if (fill) begin
            valid_q[req_idx][victim_q] <= 1'b1;
            dirty_q[req_idx][victim_q] <= 1'b0;
            lru_q[req_idx]             <= ~victim_q;
        end else if (hit_acc) begin
            lru_q[req_idx] <= ~hit_way;
            if (WRITE) dirty_q[req_idx][hit_way] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[req_idx][victim_q]  <= req_tag;
            data_q[req_idx][victim_q] <= block_q;
        end else if (hit_acc && WRITE) begin
            data_q[req_idx][hit_way][{req_off, 3'b000} +: 8] <= WRITEDATA;
        end
    end

    assign BUSYWAIT      = RESET && ((state_q != StIdle) || (req && !hit));
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_addr_q;
    assign MEM_WRITEDATA = mem_wdata_q;
    assign HIT_COUNT     = hit_cnt_q;
    assign MISS_COUNT    = miss_cnt_q;

endmodule
